seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter: NUM_DIGITS, default 4, number of multiplexed seven-segment digits (2..8).
REQ-002 Parameter: DATA_W, default 16, width of the binary input value (4..32).
REQ-003 Parameter: REFRESH_DIV, default 100000, clk cycles per digit dwell (>=2).
REQ-004 Port: clk  in  1  single system clock; all state rising-edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port: num  in  DATA_W  binary value to display.
REQ-007 Port: load  in  1  single-cycle request to capture num and start conversion.
REQ-008 Port: hex_mode  in  1  sampled with load; 1 = hexadecimal, 0 = decimal.
REQ-009 Port: blank_lz  in  1  live control; 1 = blank leading zeros.
REQ-010 Port: busy  out  1  conversion in progress; load ignored while high.
REQ-011 Port: an  out  NUM_DIGITS  digit enables, active-low, one-hot; an[0] = rightmost digit.
REQ-012 Port: seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-013 Port: ovf  out  1  displayed value exceeds NUM_DIGITS digits.

Function
REQ-014 FSM states: IDLE, CONVERT, COMMIT; IDLE->CONVERT on load; CONVERT->COMMIT after final shift; COMMIT->IDLE unconditionally.
REQ-015 load sampled at edge k in IDLE captures num and hex_mode; busy is 1 from edge k until edge k+DATA_W+1, where it returns to 0.
REQ-016 Decimal mode: iterative double-dabble, one input bit per cycle, MSB first, exactly DATA_W shift cycles; add-3 applied to every BCD digit >=5 before each shift.
REQ-017 Hex mode: digit i = captured num[4i+3:4i] (zero-extended beyond DATA_W); shifter still runs DATA_W cycles so latency is mode-independent.
REQ-018 Overflow: decimal, any 1 shifted out of the top BCD digit; hex, any nonzero bit of num above 4*NUM_DIGITS-1; sticky for the conversion.
REQ-019 Display digit registers, mode and ovf update atomically at the COMMIT edge (k+DATA_W+1); old value is shown unchanged during conversion.
REQ-020 load asserted while busy is dropped (not queued); load and COMMIT in the same cycle: load dropped.
REQ-021 Scan: prescaler counts 0..REFRESH_DIV-1; at wrap, digit index advances, NUM_DIGITS-1 wraps to 0.
REQ-022 an drives exactly one low bit, matching current digit index; seg is a pure function of registered index and display registers.
REQ-023 Glyphs: 0-9, A, b, C, d, E, F in standard patterns; blank = 7'h7F; dash (g only lit) = 7'h3F.
REQ-024 ovf=1: every digit shows dash regardless of blank_lz.
REQ-025 blank_lz=1: digit i>0 blanked iff it and all higher digits are 0; digit 0 never blanked (value 0 shows "0").
REQ-026 Scan and prescaler run continuously, independent of FSM state and busy.

Reset
REQ-027 rst_n low: FSM=IDLE, busy=0, ovf=0, display digits=0, mode=decimal, prescaler=0, digit index=0.
REQ-028 During reset an = all ones, seg = 7'h7F; after release, an[0] low and display shows "0" (blank_lz=1) or all zeros (blank_lz=0).
REQ-029 Reset mid-conversion aborts it; no partial result is committed.
REQ-030 rst_n deassertion takes effect at the next clk edge; no load accepted on that edge.

Structure
REQ-031 Package seg_pkg holds the FSM state enum, glyph lookup function, SEG_BLANK and SEG_DASH constants.
REQ-032 Sub-module bin_to_bcd_seq (parameters DATA_W, NUM_DIGITS) holds the shift/add-3 datapath, start/done/ovf handshake; top holds FSM commit, display registers and scan.
REQ-033 All counter widths derived with $clog2 from parameters; no hardcoded widths.

Verification
REQ-034 Defaults, REFRESH_DIV=4: load num=1234 decimal -> busy high 17 cycles, then digits 1,2,3,4 on an[3..0], each held 4 cycles, ovf=0.
REQ-035 load num=16'h00A5, hex_mode=1, blank_lz=1 -> digits blank,blank,A,5 (seg 7'h08, 7'h12); blank_lz=0 -> 0,0,A,5.
REQ-036 load num=10000 decimal -> ovf=1, all four digits 7'h3F; then load 9999 -> ovf=0, shows 9999.
REQ-037 load num=0, blank_lz=1 -> only digit 0 shows 7'h40; others 7'h7F.
REQ-038 Second load 5 cycles after first -> ignored, first result committed; rst_n low at cycle 8 of a conversion -> busy=0, display "0", no commit.
REQ-039 Run 3*NUM_DIGITS*REFRESH_DIV cycles -> an always one-hot low, index sequence 0,1,2,3,0 with no skipped or repeated digit.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types, glyph table and segment constants for the seven-segment scan driver
// Contents:
//   state_t    conversion FSM state (IDLE, CONVERT, COMMIT)
//   SEG_BLANK  all segments off (active-low)
//   SEG_DASH   only segment g lit (active-low)
//   glyph()    nibble to active-low {g,f,e,d,c,b,a} pattern
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_COMMIT
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // A decimal display register can never legally hold a nibble above 9;
    // should one appear, show a dash rather than a misleading hex letter.
    function automatic logic [6:0] glyph(input logic [3:0] digit, input logic hex);
        logic [6:0] g;
        case (digit)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            default: g = 7'h0E;
        endcase
        if (!hex && digit > 4'd9) begin
            g = SEG_DASH;
        end
        return g;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to BCD converter with hex pass-through
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       one-cycle pulse: capture din and hex_mode, begin conversion
//   din         binary value
//   hex_mode    1 = digits are raw nibbles of din, 0 = decimal conversion
//   done        high during the cycle whose closing edge performs the final shift
//   bcd         NUM_DIGITS packed 4-bit digits, digit 0 in the low nibble
//   ovf         value does not fit in NUM_DIGITS digits (sticky per conversion)
module bin_to_bcd_seq #(
    parameter int DATA_W     = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_W-1:0]       din,
    input  logic                    hex_mode,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    ovf
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int WW = (DATA_W > BW) ? DATA_W : BW;
    localparam int CW = $clog2(DATA_W);

    logic [DATA_W-1:0] sreg;
    logic [BW-1:0]     bcd_r;
    logic [BW-1:0]     adj;
    logic [WW-1:0]     din_w;
    logic [CW-1:0]     cnt;
    logic              running;
    logic              hex_r;
    logic              ovf_r;

    assign din_w = WW'(din);
    assign done  = running && (cnt == CW'(DATA_W - 1));
    assign bcd   = bcd_r;
    assign ovf   = ovf_r;

    always_comb begin
        adj = bcd_r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end
        end
    end

    // Hex results are loaded at start; the counter still runs DATA_W cycles
    // so both modes complete with identical latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            bcd_r   <= '0;
            cnt     <= '0;
            running <= 1'b0;
            hex_r   <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (start) begin
            sreg    <= din;
            cnt     <= '0;
            running <= 1'b1;
            hex_r   <= hex_mode;
            if (hex_mode) begin
                bcd_r <= din_w[BW-1:0];
                ovf_r <= |(din_w >> BW);
            end else begin
                bcd_r <= '0;
                ovf_r <= 1'b0;
            end
        end else if (running) begin
            cnt  <= cnt + 1'b1;
            sreg <= sreg << 1;
            if (!hex_r) begin
                // A 1 leaving the top digit means the value needs another digit.
                bcd_r <= {adj[BW-2:0], sreg[DATA_W-1]};
                ovf_r <= ovf_r | adj[BW-1];
            end
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed seven-segment driver with decimal/hex conversion and commit
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   num         binary value to display
//   load        one-cycle request to capture num (ignored while busy)
//   hex_mode    sampled with load: 1 = hex, 0 = decimal
//   blank_lz    live: blank leading zero digits (digit 0 always shown)
//   busy        conversion in progress
//   an          active-low one-hot digit enables, an[0] = rightmost digit
//   seg         active-low segments {g,f,e,d,c,b,a}
//   ovf         displayed value does not fit; all digits show a dash
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     num,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  ovf
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    state_t        state;
    logic          run;
    logic [BW-1:0] disp;
    logic          disp_hex;
    logic          conv_hex;
    logic [PW-1:0] pre;
    logic [IW-1:0] idx;

    logic          start;
    logic          conv_done;
    logic [BW-1:0] conv_bcd;
    logic          conv_ovf;
    logic [3:0]    digit;
    logic          lead_zero;

    // run stays low through the first edge after reset release, so that edge
    // can neither accept a load nor light a digit.
    assign start = run && (state == ST_IDLE) && load;

    bin_to_bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .din      (num),
        .hex_mode (hex_mode),
        .done     (conv_done),
        .bcd      (conv_bcd),
        .ovf      (conv_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            run      <= 1'b0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
            disp     <= '0;
            disp_hex <= 1'b0;
            conv_hex <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_CONVERT;
                        busy     <= 1'b1;
                        conv_hex <= hex_mode;
                    end
                end
                ST_CONVERT: begin
                    if (conv_done) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    disp     <= conv_bcd;
                    ovf      <= conv_ovf;
                    disp_hex <= conv_hex;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PW'(REFRESH_DIV - 1)) begin
            pre <= '0;
            idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    assign digit     = disp[{idx, 2'b00} +: 4];
    assign lead_zero = ((disp >> {idx, 2'b00}) == '0);

    always_comb begin
        an  = '1;
        seg = SEG_BLANK;
        if (run) begin
            an = ~(NUM_DIGITS'(1) << idx);
            if (ovf) begin
                seg = SEG_DASH;
            end else if (blank_lz && (idx != '0) && lead_zero) begin
                seg = SEG_BLANK;
            end else begin
                seg = glyph(digit, disp_hex);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - scoreboard bench for seg_scan_driver
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int DW = 16;
    localparam int RD = 4;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [ND-1:0][6:0] segs;
        logic               ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] num;
    logic          load;
    logic          hex_mode;
    logic          blank_lz;
    logic          busy;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          ovf;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    int   snap_cnt = 0;
    int   snap_seen = 0;
    bit   mon_busy = 1'b0;

    seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .DATA_W      (DW),
        .REFRESH_DIV (RD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .num      (num),
        .load     (load),
        .hex_mode (hex_mode),
        .blank_lz (blank_lz),
        .busy     (busy),
        .an       (an),
        .seg      (seg),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Display contents as arithmetic on the value: digit i is (v / base^i) % base.
    function automatic exp_t model(input int unsigned v, input bit hex, input bit blz);
        exp_t              e;
        int unsigned       base;
        longint unsigned   p;
        longint unsigned   hi;
        base = hex ? 16 : 10;
        p = 1;
        for (int i = 0; i < ND; i++) p = p * base;
        e.ovf = (longint'(v) >= p);
        p = 1;
        for (int i = 0; i < ND; i++) begin
            hi = longint'(v) / p;
            if (e.ovf)                     e.segs[i] = 7'h3F;
            else if (blz && i > 0 && hi == 0) e.segs[i] = 7'h7F;
            else                           e.segs[i] = GLYPH[int'(hi % base)];
            p = p * base;
        end
        return e;
    endfunction

    task automatic do_load(input int unsigned v, input bit hex, input bit push);
        @(negedge clk);
        num      = v[DW-1:0];
        hex_mode = hex;
        if (push) exp_q.push_back(model(v, hex, blank_lz));
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic snap(input int unsigned v, input bit hex);
        exp_q.push_back(model(v, hex, blank_lz));
        snap_cnt++;
    endtask

    task automatic wait_mon();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || mon_busy || snap_seen != snap_cnt) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("monitor_timeout", (t < 400) ? 1 : 0, 1);
    endtask

    // Monitor: a commit (busy falling) or a snapshot request pops one expectation
    // and captures one full scan period of seg per digit.
    initial begin
        int        hi;
        bit        pb;
        bit        trig;
        exp_t      e;
        logic [6:0] got [ND];
        bit        seen [ND];
        hi = 0;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hi = 0;
                pb = 1'b0;
                continue;
            end
            trig = 1'b0;
            if (pb && !busy) begin
                check("busy_len", hi, DW + 1);
                trig = 1'b1;
            end
            if (snap_cnt != snap_seen) begin
                snap_seen = snap_cnt;
                trig = 1'b1;
            end
            pb = busy;
            hi = busy ? hi + 1 : 0;
            if (trig) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    for (int i = 0; i < ND; i++) begin
                        got[i]  = 7'h7F;
                        seen[i] = 1'b0;
                    end
                    for (int c = 0; c < ND * RD; c++) begin
                        if (c > 0) @(negedge clk);
                        for (int i = 0; i < ND; i++) begin
                            if (an[i] == 1'b0) begin
                                got[i]  = seg;
                                seen[i] = 1'b1;
                            end
                        end
                    end
                    for (int i = 0; i < ND; i++) begin
                        check($sformatf("digit%0d_seen", i), seen[i], 1);
                        check($sformatf("digit%0d_seg", i), got[i], e.segs[i]);
                    end
                    check("ovf", ovf, e.ovf);
                end
                pb = busy;
                hi = busy ? 1 : 0;
                mon_busy = 1'b0;
            end
        end
    end

    // Scan checker: one-hot low enables, index steps by one mod ND, RD-cycle dwell.
    initial begin
        int prev;
        int dwell;
        int zeros;
        int idx;
        bit first;
        prev  = -1;
        dwell = 0;
        first = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = -1;
                continue;
            end
            if (prev == -1 && an == '1) continue;
            zeros = 0;
            idx   = -1;
            for (int i = ND - 1; i >= 0; i--) begin
                if (an[i] == 1'b0) begin
                    zeros++;
                    idx = i;
                end
            end
            check("an_onehot", zeros, 1);
            if (prev == -1) begin
                check("scan_start_idx", idx, 0);
                prev  = idx;
                dwell = 1;
                first = 1'b1;
            end else if (idx == prev) begin
                dwell++;
            end else begin
                check("scan_next_idx", idx, (prev + 1) % ND);
                if (!first) check("scan_dwell", dwell, RD);
                first = 1'b0;
                prev  = idx;
                dwell = 1;
            end
        end
    end

    initial begin
        int unsigned v;
        bit          hx;
        rst_n    = 1'b0;
        num      = '0;
        load     = 1'b0;
        hex_mode = 1'b0;
        blank_lz = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_an", an, 4'hE);
        snap(0, 0);
        wait_mon();

        blank_lz = 1'b0;
        snap(0, 0);
        wait_mon();

        do_load(1234, 0, 1);
        wait_mon();
        blank_lz = 1'b1;
        do_load(16'h00A5, 1, 1);
        wait_mon();
        blank_lz = 1'b0;
        do_load(16'h00A5, 1, 1);
        wait_mon();
        do_load(10000, 0, 1);
        wait_mon();
        do_load(9999, 0, 1);
        wait_mon();
        blank_lz = 1'b1;
        do_load(0, 0, 1);
        wait_mon();

        // Load while busy is dropped.
        do_load(1234, 0, 1);
        repeat (4) @(negedge clk);
        num  = 16'd4321;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_mon();

        // Load landing on the commit edge is dropped.
        do_load(5678, 0, 1);
        repeat (16) @(negedge clk);
        num  = 16'd1111;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("busy_after_commit_load", busy, 0);
        wait_mon();

        for (int n = 0; n < 14; n++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 9999);
                1:       v = $urandom & 32'hFFFF;
                2:       v = $urandom_range(0, 99);
                default: v = $urandom_range(9990, 10010);
            endcase
            hx       = 1'($urandom_range(0, 1));
            blank_lz = 1'($urandom_range(0, 1));
            do_load(v, hx, 1);
            wait_mon();
        end

        // Reset in the middle of a conversion: nothing committed, display cleared.
        do_load(4321, 0, 1);
        wait_mon();
        do_load(8765, 0, 0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_an", an, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        snap(0, 0);
        wait_mon();

        repeat (3 * ND * RD) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
